uart_resp_tx: RTL and testbench
===============================

# uart_resp_tx

UART transmitter that returns the result of each I2C transaction to the host, completing the host link opposite the command receiver. On a one-cycle completion pulse from the I2C master it captures device address, R/W bit, register address and 16-bit data, then serialises them as consecutive 8N1 bytes on TXD. It sits between the I2C master and the board TXD pin.

## Interface
- CLK_FREQ, 100000000, system clock frequency in Hz
- UART_BPS, 115200, baud rate; BPS_CNT = CLK_FREQ/UART_BPS (868 at defaults), must be 2..32767
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- i2c_done  in  1  one-cycle pulse: I2C transaction finished, inputs below valid this cycle
- device_addr  in  7  7-bit I2C device address
- rw  in  1  1 = read, 0 = write
- reg_addr  in  8  register address
- i2c_rdata  in  16  read data (echo of write data when rw=0)
- ack_err  in  1  1 = slave NACKed during the transaction
- TXD  out  1  serial output, idle high
- tx_busy  out  1  frame in progress
- tx_done  out  1  one-cycle pulse: frame fully sent

## Operation
- Frame bytes, in order: B0 = {device_addr, rw}, B1 = reg_addr, B2 = i2c_rdata[15:8], B3 = i2c_rdata[7:0]; optional B4 status (see Configuration).
- Each byte 8N1: start bit 0, data bits LSB first, one stop bit 1; each bit exactly BPS_CNT cycles.
- No gap between bytes: next start bit follows the previous stop bit directly.
- All inputs captured into a frame register on the accepting i2c_done edge; inputs may change afterwards.
- i2c_done accepted only when tx_busy = 0; while busy it is ignored, not queued, no error flag.
- FSM: IDLE -> START -> DATA (8 bits, bit index 0..7) -> STOP -> START of next byte while byte index < last, else IDLE.
- Bit counter 15 bits, counts 0..BPS_CNT-1, wraps to 0 and advances bit/state on BPS_CNT-1.
- Byte index 3 bits, 0..last, cleared on entry to IDLE.

## Timing
- Reset values: TXD = 1, tx_busy = 0, tx_done = 0, FSM = IDLE, counters 0, frame register 0.
- Cycle N: i2c_done = 1 with tx_busy = 0. Cycle N+1: tx_busy = 1, TXD = 0 (start of B0).
- TXD changes only at bit boundaries, registered (no glitches).
- Frame length F = 40·BPS_CNT cycles (50·BPS_CNT with status byte); last stop bit occupies cycles up to N+F.
- Cycle N+F+1: tx_busy = 0, tx_done = 1 for exactly one cycle, TXD = 1.
- i2c_done in cycle N+F+1 is accepted (tx_busy already 0): new start bit in N+F+2; tx_done still pulses.
- rst asserted mid-frame: at the next edge TXD = 1, tx_busy = 0, no tx_done, frame abandoned; rst dominates a simultaneous i2c_done.

## Configuration
- UART_RESP_STATUS_EN defined: fifth byte B4 appended = 8'hEE if captured ack_err = 1, else 8'h00; F = 50·BPS_CNT; last byte index 4.
- Not defined: four-byte frame, ack_err input unused; last byte index 3.

## Structure
- Shared package uart_pkg: default CLK_FREQ/UART_BPS, BPS_CNT derivation, counter width 15, FSM state encodings, frame byte count constants, status codes 8'h00/8'hEE.
- One sub-module, uart_tx_byte: loads one byte on a start strobe, drives START/DATA/STOP with its own bit counter, returns a one-cycle byte_done; uart_resp_tx holds the frame register, byte index and tx_busy/tx_done.

## Test plan
- Reset: hold rst 5 cycles -> TXD = 1, tx_busy = 0, tx_done = 0 throughout and after release.
- Single read: i2c_done with device_addr 7'h50, rw 1, reg_addr 8'h1A, i2c_rdata 16'hBEEF -> TXD decodes 8'hA1, 8'h1A, 8'hBE, 8'hEF at 868 cycles/bit; tx_done exactly 40·868+1 cycles after i2c_done.
- Busy drop: second i2c_done (rdata 16'h1234) at mid-frame -> ignored; only first frame sent, single tx_done.
- Back-to-back: i2c_done coincident with tx_done -> new start bit on the next cycle, TXD never returns to extended idle.
- Reset mid-frame: rst during bit 3 of B2 -> TXD = 1 next cycle, tx_busy = 0, no tx_done; fresh i2c_done then sends a complete correct frame.
- With UART_RESP_STATUS_EN, ack_err 1 -> fifth byte 8'hEE, tx_done at 50·868+1 cycles; ack_err 0 -> fifth byte 8'h00.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, state encodings and frame helpers for the
// I2C result transmitter (uart_resp_tx) and its byte serialiser.
package uart_pkg;

  // Default clock and line rate; bit period is their integer ratio
  localparam int DEF_CLK_FREQ = 100_000_000;
  localparam int DEF_UART_BPS = 115_200;

  // Width of the per-bit cycle counter (bit period up to 32767 cycles)
  localparam int CNT_W = 15;

  // Serialiser FSM encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Frame length in bytes without and with the trailing status byte
  localparam int FRAME_BYTES_BASE   = 4;
  localparam int FRAME_BYTES_STATUS = 5;

  // Status byte values: transaction acknowledged / slave NACKed
  localparam logic [7:0] STATUS_OK   = 8'h00;
  localparam logic [7:0] STATUS_NACK = 8'hEE;

  // Everything captured from the I2C master for one response frame
  typedef struct packed {
    logic [6:0]  device_addr;
    logic        rw;
    logic [7:0]  reg_addr;
    logic [15:0] rdata;
    logic [7:0]  status;
  } frame_t;

  // Clock cycles per UART bit
  function automatic int calc_bps_cnt(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

  // Select the byte sent at position idx of the frame
  function automatic logic [7:0] frame_byte(input frame_t f, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = {f.device_addr, f.rw};
      3'd1:    b = f.reg_addr;
      3'd2:    b = f.rdata[15:8];
      3'd3:    b = f.rdata[7:0];
      default: b = f.status;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: serialises one 8N1 byte. A start strobe loads the byte and
// begins the start bit on the next cycle; byte_done is high during the last
// cycle of the stop bit so a following start strobe can butt the next byte
// directly against this one with no idle gap.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int BPS_CNT = calc_bps_cnt(DEF_CLK_FREQ, DEF_UART_BPS)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] din,
  output logic       txd,
  output logic       byte_done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_txd;
  logic             w_bit_end;

  assign w_bit_end = (r_cnt == CNT_LAST);
  assign byte_done = (r_state == ST_STOP) && w_bit_end;
  assign txd       = r_txd;

  // Bit-period counter and START/DATA/STOP sequencing; TXD is registered so
  // it only ever changes on a bit boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_txd     <= 1'b1;
    end else if (start) begin
      r_state   <= ST_START;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= din;
      r_txd     <= 1'b0;
    end else begin
      case (r_state)
        ST_START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= ST_DATA;
            r_txd   <= r_shift[0];
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_state <= ST_STOP;
              r_txd   <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_shift   <= r_shift >> 1;
              r_txd     <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= ST_IDLE;
            r_txd     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cnt <= '0;
          r_txd <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_resp_tx.sv
// uart_resp_tx: captures the result of an I2C transaction on i2c_done and
// sends it to the host as back-to-back 8N1 bytes
// {device_addr,rw}, reg_addr, rdata[15:8], rdata[7:0].
// Build option: define UART_RESP_STATUS_EN to append a fifth status byte
// (8'hEE when the slave NACKed, 8'h00 otherwise).
module uart_resp_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int UART_BPS = DEF_UART_BPS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i2c_done,
  input  logic [6:0]  device_addr,
  input  logic        rw,
  input  logic [7:0]  reg_addr,
  input  logic [15:0] i2c_rdata,
  input  logic        ack_err,
  output logic        TXD,
  output logic        tx_busy,
  output logic        tx_done
);

  localparam int BPS_CNT = calc_bps_cnt(CLK_FREQ, UART_BPS);

`ifdef UART_RESP_STATUS_EN
  localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES_STATUS - 1);
  logic [7:0] w_status;
  assign w_status = ack_err ? STATUS_NACK : STATUS_OK;
`else
  localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES_BASE - 1);
  logic [7:0] w_status;
  logic       w_unused_ack_err;
  assign w_status         = STATUS_OK;
  assign w_unused_ack_err = ack_err;
`endif

  frame_t     r_frame;
  logic [2:0] r_byte_idx;
  logic       r_busy;
  logic       r_done;
  logic       w_accept;
  logic       w_byte_done;
  logic       w_last;
  logic       w_start;
  logic [7:0] w_byte;

  // A new frame is accepted only while idle; the first byte comes straight
  // from the inputs so its start bit appears on the very next cycle
  assign w_accept = i2c_done && !r_busy;
  assign w_last   = (r_byte_idx == LAST_IDX);
  assign w_start  = w_accept || (w_byte_done && !w_last);
  assign w_byte   = w_accept ? {device_addr, rw}
                             : frame_byte(r_frame, r_byte_idx + 3'd1);

  assign tx_busy = r_busy;
  assign tx_done = r_done;

  uart_tx_byte #(
    .BPS_CNT (BPS_CNT)
  ) u_tx_byte (
    .clk       (clk),
    .rst       (rst),
    .start     (w_start),
    .din       (w_byte),
    .txd       (TXD),
    .byte_done (w_byte_done)
  );

  // Frame capture, byte sequencing and the busy / one-cycle done flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame    <= '0;
      r_byte_idx <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_frame.device_addr <= device_addr;
        r_frame.rw          <= rw;
        r_frame.reg_addr    <= reg_addr;
        r_frame.rdata       <= i2c_rdata;
        r_frame.status      <= w_status;
        r_byte_idx          <= '0;
        r_busy              <= 1'b1;
      end else if (w_byte_done) begin
        if (w_last) begin
          r_byte_idx <= '0;
          r_busy     <= 1'b0;
          r_done     <= 1'b1;
        end else begin
          r_byte_idx <= r_byte_idx + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_resp_tx.sv
// tb_uart_resp_tx: directed bench for uart_resp_tx. A short bit period keeps
// every frame small; each frame is checked cycle by cycle against the
// expected 8N1 bit stream and decoded at bit centres.
module tb_uart_resp_tx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int UART_BPS = 100_000;
  localparam int BPS      = CLK_FREQ / UART_BPS;
`ifdef UART_RESP_STATUS_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif
  localparam int F = NB * 10 * BPS;

  logic        clk = 1'b0;
  logic        rst;
  logic        i2c_done;
  logic [6:0]  device_addr;
  logic        rw;
  logic [7:0]  reg_addr;
  logic [15:0] i2c_rdata;
  logic        ack_err;
  logic        TXD;
  logic        tx_busy;
  logic        tx_done;

  int assertCount = 0;
  int failCount   = 0;

  // Free-running system clock
  always #5 clk = ~clk;

  uart_resp_tx #(
    .CLK_FREQ (CLK_FREQ),
    .UART_BPS (UART_BPS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i2c_done    (i2c_done),
    .device_addr (device_addr),
    .rw          (rw),
    .reg_addr    (reg_addr),
    .i2c_rdata   (i2c_rdata),
    .ack_err     (ack_err),
    .TXD         (TXD),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done)
  );

  // Single comparison point: counts and reports every check
  task automatic checkOutput(input string tag, input logic [39:0] observed,
                             input logic [39:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Present one transaction result and raise i2c_done for the current cycle
  task automatic applyStimulus(input logic [6:0] dev, input logic rwBit,
                               input logic [7:0] regA, input logic [15:0] data,
                               input logic ack);
    device_addr = dev;
    rw          = rwBit;
    reg_addr    = regA;
    i2c_rdata   = data;
    ack_err     = ack;
    i2c_done    = 1'b1;
  endtask

  function automatic logic [7:0] expByte(input logic [39:0] frame, input int k);
    return frame[39 - 8*k -: 8];
  endfunction

  // Follow one frame from the cycle after i2c_done; optionally inject a
  // second i2c_done or a reset at a given cycle offset
  task automatic runFrame(input string name, input logic [39:0] expFrame,
                          input int injectAt, input int abortAt);
    logic [7:0] dec [5];
    int         badCycles = 0;
    bit         aborted   = 1'b0;
    int         c         = 0;
    for (int k = 0; k < 5; k++) dec[k] = 8'h00;
    @(negedge clk);
    i2c_done = 1'b0;
    while (c < F && !aborted) begin
      int         byteIdx;
      int         pos;
      logic [7:0] b;
      logic       expBit;
      byteIdx = c / (10 * BPS);
      pos     = (c / BPS) % 10;
      b       = expByte(expFrame, byteIdx);
      if (pos == 0)      expBit = 1'b0;
      else if (pos == 9) expBit = 1'b1;
      else               expBit = b[pos-1];
      if (TXD !== expBit || tx_busy !== 1'b1 || tx_done !== 1'b0) badCycles++;
      if ((c % BPS) == BPS/2 && pos >= 1 && pos <= 8) dec[byteIdx][pos-1] = TXD;
      if (c == injectAt) begin
        i2c_rdata = 16'h1234;
        i2c_done  = 1'b1;
      end
      if (c == abortAt) begin
        rst     = 1'b1;
        aborted = 1'b1;
      end
      @(negedge clk);
      i2c_done = 1'b0;
      c++;
    end
    checkOutput({name, " bit stream"}, 40'(badCycles), 40'd0);
    if (aborted) begin
      checkOutput({name, " reset TXD"}, 40'(TXD), 40'd1);
      checkOutput({name, " reset busy"}, 40'(tx_busy), 40'd0);
      checkOutput({name, " reset done"}, 40'(tx_done), 40'd0);
      rst = 1'b0;
    end else begin
      checkOutput({name, " tx_done"}, 40'(tx_done), 40'd1);
      checkOutput({name, " busy clear"}, 40'(tx_busy), 40'd0);
      checkOutput({name, " TXD idle"}, 40'(TXD), 40'd1);
      for (int k = 0; k < NB; k++)
        checkOutput($sformatf("%s byte%0d", name, k), 40'(dec[k]), 40'(expByte(expFrame, k)));
    end
  endtask

  // Expect a quiet line (idle high, not busy, no done) for n cycles
  task automatic idleCheck(input string tag, input int n);
    int bad = 0;
    repeat (n) begin
      @(negedge clk);
      if (TXD !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    checkOutput(tag, 40'(bad), 40'd0);
  endtask

  // Directed sequence: reset, single read, busy drop, back-to-back,
  // reset mid-frame and recovery
  initial begin
    int bad;
    rst         = 1'b1;
    i2c_done    = 1'b0;
    device_addr = 7'h00;
    rw          = 1'b0;
    reg_addr    = 8'h00;
    i2c_rdata   = 16'h0000;
    ack_err     = 1'b0;
    bad         = 0;
    repeat (5) begin
      @(negedge clk);
      if (TXD !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    checkOutput("reset hold", 40'(bad), 40'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post-reset TXD", 40'(TXD), 40'd1);
    checkOutput("post-reset busy", 40'(tx_busy), 40'd0);
    checkOutput("post-reset done", 40'(tx_done), 40'd0);
    idleCheck("post-reset idle", 10);

    $display("[TB] single read");
    applyStimulus(7'h50, 1'b1, 8'h1A, 16'hBEEF, 1'b0);
    runFrame("read", {8'hA1, 8'h1A, 8'hBE, 8'hEF, 8'h00}, -1, -1);
    idleCheck("idle after read", 5);

    $display("[TB] busy drop");
    applyStimulus(7'h21, 1'b0, 8'h80, 16'h5AA5, 1'b1);
    runFrame("drop", {8'h42, 8'h80, 8'h5A, 8'hA5, 8'hEE}, F/2, -1);
    idleCheck("no queued frame", F + 20);

    $display("[TB] back-to-back");
    applyStimulus(7'h3C, 1'b0, 8'h05, 16'h00FF, 1'b0);
    runFrame("b2b first", {8'h78, 8'h05, 8'h00, 8'hFF, 8'h00}, -1, -1);
    applyStimulus(7'h7F, 1'b1, 8'hFF, 16'h8001, 1'b1);
    runFrame("b2b second", {8'hFF, 8'hFF, 8'h80, 8'h01, 8'hEE}, -1, -1);
    idleCheck("idle after b2b", 5);

    $display("[TB] reset mid-frame");
    applyStimulus(7'h50, 1'b1, 8'h1A, 16'hBEEF, 1'b0);
    runFrame("abort", {8'hA1, 8'h1A, 8'hBE, 8'hEF, 8'h00}, -1, 20*BPS + 4*BPS + BPS/2);
    idleCheck("idle after abort", F + 20);
    applyStimulus(7'h11, 1'b1, 8'h42, 16'hC3C3, 1'b1);
    runFrame("fresh", {8'h23, 8'h42, 8'hC3, 8'hC3, 8'hEE}, -1, -1);
    idleCheck("final idle", 5);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
